// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-detection inputs and pipeline control outputs of pipe_hazard_ctrl.
interface pipe_hazard_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_load, redirect, mem_req, dmem_ready;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, mem_err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, redirect, mem_req, dmem_ready,
    input pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, mem_err, state,
    stall_cnt, flush_cnt
  );
  modport slave (
    input id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_load, redirect, mem_req, dmem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, mem_err, state,
    stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline,
// with data-memory timeout detection and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  pipe_hazard_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEMWAIT = 2'd2} state_t;
  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  state_t cur, nxt;
  logic pend, err;
  logic [15:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] stalls, flushes;
  logic luh, mstall, hold_all, lu_stall, flush_if, bubble, take;
  assign luh = hz.ex_load & (hz.ex_rd != 5'd0) &
               ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) | (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
  assign mstall = hz.mem_req & ~hz.dmem_ready;
  // The illegal encoding falls through to the RUN branch.
  always_comb begin
    nxt = RUN;
    hold_all = 1'b0;
    lu_stall = 1'b0;
    flush_if = 1'b0;
    bubble = 1'b0;
    take = 1'b0;
    if (cur == FLUSH) begin
      hold_all = mstall;
      flush_if = ~mstall;
      nxt = mstall ? MEMWAIT : RUN;
    end else if (cur == MEMWAIT) begin
      hold_all = ~hz.dmem_ready;
      nxt = hz.dmem_ready ? (pend ? FLUSH : RUN) : MEMWAIT;
    end else if (mstall) begin
      hold_all = 1'b1;
      nxt = MEMWAIT;
    end else if (hz.redirect) begin
      flush_if = 1'b1;
      bubble = 1'b1;
      take = 1'b1;
      nxt = FLUSH;
    end else begin
      lu_stall = luh;
      bubble = luh;
    end
  end
  // Outside MEMWAIT a stall is the first waiting cycle; inside it the count saturates.
  assign wcnt_n = (cur == MEMWAIT) ? (hz.dmem_ready ? 16'd0 : (wcnt == TMO ? wcnt : wcnt + 16'd1))
                                   : {15'd0, hold_all};
  assign hz.pc_hold = rst & (hold_all | lu_stall);
  assign hz.ifid_hold = rst & (hold_all | lu_stall);
  assign hz.idex_hold = rst & hold_all;
  assign hz.exmem_hold = rst & hold_all;
  assign hz.ifid_flush = ~rst | flush_if;
  assign hz.idex_bubble = ~rst | bubble;
  assign hz.state = cur;
  assign hz.mem_err = err;
  assign hz.stall_cnt = stalls;
  assign hz.flush_cnt = flushes;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cur <= RUN;
    else cur <= nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= 1'b0;
      wcnt <= 16'd0;
      err <= 1'b0;
      stalls <= '0;
      flushes <= '0;
    end else begin
      pend <= (cur == MEMWAIT) ? (pend & ~hz.dmem_ready) : (pend | ((cur == FLUSH) & mstall));
      wcnt <= wcnt_n;
      err <= err | (wcnt_n == TMO);
      stalls <= stalls + CNT_W'(hz.pc_hold & ~&stalls);
      flushes <= flushes + CNT_W'(take & ~&flushes);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, reset corner cases and a randomized
// run against an event-level reference model of the hazard sequencer.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4, TMO = 4, CMAX = (1 << CW) - 1;
  localparam logic [5:0] N = 6'b000000, LU = 6'b110010, RD = 6'b001010, FL = 6'b001000, HA = 6'b110101;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_if #(.CNT_W(CW)) hz();
  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .hz(hz));
  logic [5:0] ctl;
  assign ctl = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold, hz.idex_bubble, hz.exmem_hold};
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, ld, rdr, mq, rdy;
    logic [5:0] ctl;
    logic [1:0] st;
    logic err;
    logic [CW-1:0] sc, fc;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0;
  bit in_wait, flush_due, m_err;
  int wait_len, m_stalls, m_flushes;
  function automatic vec_t mk(input int rs1, rs2, u1, u2, rd, ld, rdr, mq, rdy,
                              input logic [5:0] c, input int st, err, sc, fc);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = u1[0]; v.u2 = u2[0]; v.ld = ld[0]; v.rdr = rdr[0]; v.mq = mq[0]; v.rdy = rdy[0];
    v.ctl = c; v.st = 2'(st); v.err = err[0]; v.sc = CW'(sc); v.fc = CW'(fc);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] r1, r2, input logic u1, u2, input logic [4:0] rd,
                       input logic ld, rdr, mq, rdy);
    hz.id_rs1 = r1; hz.id_rs2 = r2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    hz.ex_rd = rd; hz.ex_load = ld; hz.redirect = rdr; hz.mem_req = mq; hz.dmem_ready = rdy;
  endtask
  task automatic chk_all(input string nm, input logic [5:0] c, input int st, err, sc, fc);
    chk({nm, " ctl"}, 32'(ctl), 32'(c));
    chk({nm, " state"}, 32'(hz.state), 32'(st));
    chk({nm, " mem_err"}, 32'(hz.mem_err), 32'(err));
    chk({nm, " stall_cnt"}, 32'(hz.stall_cnt), 32'(sc));
    chk({nm, " flush_cnt"}, 32'(hz.flush_cnt), 32'(fc));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit luh, ms, frz, rok, lok, bias;
    logic [5:0] ec;
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 0,0));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, LU,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 1,0));
    tbl.push_back(mk(0,0,0,1,0,1,0,0,1, N, 0,0, 1,0));
    tbl.push_back(mk(7,3,1,1,7,1,0,0,1, LU,0,0, 1,0));
    tbl.push_back(mk(7,3,0,1,7,1,0,0,1, N, 0,0, 2,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1, RD,0,0, 2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, FL,1,0, 2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,0,0, 2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 3,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, N, 2,0, 5,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 5,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1, RD,0,0, 5,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,1,0, 5,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 6,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, N, 2,0, 7,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, FL,1,0, 7,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 7,2));
    tbl.push_back(mk(0,5,0,1,5,1,1,0,1, RD,0,0, 7,2));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, FL,1,0, 7,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 7,3));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,0, HA,0,0, 7,3));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, N, 2,0, 8,3));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1, RD,0,0, 8,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, FL,1,0, 8,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,0, 8,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,0,0, 8,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 9,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 10,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,0, 11,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, HA,2,1, 12,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, N, 2,1, 13,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,1, 13,4));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, LU,0,1, 13,4));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, LU,0,1, 14,4));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, LU,0,1, 15,4));
    tbl.push_back(mk(0,5,0,1,5,1,0,0,1, LU,0,1, 15,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, N, 0,1, 15,4));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("reset%0d", i), RD, 0, 0, 0, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].ld, tbl[i].rdr, tbl[i].mq, tbl[i].rdy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].ctl, int'(tbl[i].st), int'(tbl[i].err), int'(tbl[i].sc), int'(tbl[i].fc));
    end
    // Asynchronous reset in the middle of a memory wait with mem_err already set.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk_all("wait_enter", HA, 0, 1, 15, 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("wait_mid", HA, 2, 1, 15, 4);
    #2 rst = 1'b0;
    #1 chk_all("async_rst", RD, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("post_rst", N, 0, 0, 0, 0);
    in_wait = 0; flush_due = 0; m_err = 0; wait_len = 0; m_stalls = 0; m_flushes = 0; bias = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (c % 40 == 0) bias = 1'($urandom_range(0, 1));
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
            bias ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1));
      rst = (c % 40 != 39);
      if (!rst) begin
        in_wait = 0; flush_due = 0; m_err = 0; wait_len = 0; m_stalls = 0; m_flushes = 0;
      end
      @(negedge clk);
      if (!rst) begin
        chk_all($sformatf("rnd%0d rst", c), RD, 0, 0, 0, 0);
        continue;
      end
      luh = hz.ex_load && hz.ex_rd != 0 &&
            ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
      ms = hz.mem_req && !hz.dmem_ready;
      frz = in_wait ? !hz.dmem_ready : ms;
      rok = !in_wait && !flush_due && !ms && hz.redirect;
      lok = !in_wait && !flush_due && !ms && !hz.redirect && luh;
      ec = {frz || lok, frz || lok, rok || (flush_due && !in_wait && !ms), frz, rok || lok, frz};
      chk_all($sformatf("rnd%0d", c), ec, in_wait ? 2 : (flush_due ? 1 : 0), int'(m_err),
              m_stalls, m_flushes);
      if (ec[5] && m_stalls < CMAX) m_stalls++;
      if (rok && m_flushes < CMAX) m_flushes++;
      if (frz) begin
        wait_len = in_wait ? wait_len + 1 : 1;
        in_wait = 1;
        if (wait_len >= TMO) m_err = 1;
      end else begin
        wait_len = 0;
        if (in_wait) in_wait = 0;
        else if (flush_due) flush_due = 0;
        else if (rok) flush_due = 1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
